// File: rtl/fifo_if_pkg.sv
// Shared definitions for the FIFO access master and the FIFO controller.
// State encoding, default strobe timing and FIFO bus widths.
package fifo_if_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam int DEF_STROBE_CYCLES = 3;
  localparam int DEF_GAP_CYCLES    = 2;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 11;

  localparam int CNT_W = 4;

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fifo_strobe_timer.sv
// Loadable down-counter with zero flag.
// Times both the strobe-low and the strobe-gap phases.
module fifo_strobe_timer
  import fifo_if_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fifo_access_master.sv
// Command-stream to fifowr/fiford strobe initiator for the FIFO controller.
// Optional counters enabled by FIFO_ACCESS_MASTER_STATS_EN.
module fifo_access_master
  import fifo_if_pkg::*;
#(
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int DATA_W        = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_rw,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              fifowr,
  output logic              fiford,
  output logic [DATA_W-1:0] fifo_in_data,
  input  logic [DATA_W-1:0] fifo_out_data,
  input  logic              nfull,
  input  logic              nempty
`ifdef FIFO_ACCESS_MASTER_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic [15:0]       stall_count
`endif
);

  logic [1:0] state;
  logic       rw_q;
  logic       zero;
  logic       accept;
  logic       strobe_end;
  logic       t_load;
  logic [CNT_W-1:0] t_val;

  assign cmd_ready = !rst && (state == ST_IDLE) &&
                     (cmd_rw ? nempty : nfull);
  assign accept     = cmd_valid && cmd_ready;
  assign strobe_end = (state == ST_ASSERT) && zero;

  assign t_load = accept || strobe_end;
  assign t_val  = accept ? CNT_W'(STROBE_CYCLES - 1)
                         : CNT_W'(GAP_CYCLES - 1);

  fifo_strobe_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .zero     (zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rw_q         <= 1'b0;
      fifowr       <= 1'b1;
      fiford       <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rw       <= 1'b0;
      rsp_rdata    <= '0;
      fifo_in_data <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            rw_q   <= cmd_rw;
            fifowr <= cmd_rw;
            fiford <= !cmd_rw;
            state  <= ST_ASSERT;
            if (!cmd_rw) begin
              fifo_in_data <= cmd_wdata;
            end
          end
        end
        ST_ASSERT: begin
          if (zero) begin
            if (rw_q) begin
              rsp_rdata <= fifo_out_data;
            end
            fifowr    <= 1'b1;
            fiford    <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rw    <= rw_q;
            state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (zero) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_ACCESS_MASTER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count    <= '0;
      rd_count    <= '0;
      stall_count <= '0;
    end else begin
      if (strobe_end && rw_q) begin
        rd_count <= sat_inc(rd_count);
      end
      if (strobe_end && !rw_q) begin
        wr_count <= sat_inc(wr_count);
      end
      if (cmd_valid && (state == ST_IDLE) && !cmd_ready) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_access_master.sv
// Randomized and directed bench for fifo_access_master.
// Outputs are checked every cycle against an age-since-accept model.
module tb_fifo_access_master;

  localparam int S = 3;
  localparam int G = 2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_rw;
  logic [W-1:0] cmd_wdata;
  logic         rsp_valid;
  logic         rsp_rw;
  logic [W-1:0] rsp_rdata;
  logic         fifowr;
  logic         fiford;
  logic [W-1:0] fifo_in_data;
  logic [W-1:0] fifo_out_data;
  logic         nfull;
  logic         nempty;
`ifdef FIFO_ACCESS_MASTER_STATS_EN
  logic [15:0]  wr_count;
  logic [15:0]  rd_count;
  logic [15:0]  stall_count;
`endif

  fifo_access_master #(
    .STROBE_CYCLES (S),
    .GAP_CYCLES    (G),
    .DATA_W        (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rw        (cmd_rw),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rw        (rsp_rw),
    .rsp_rdata     (rsp_rdata),
    .fifowr        (fifowr),
    .fiford        (fiford),
    .fifo_in_data  (fifo_in_data),
    .fifo_out_data (fifo_out_data),
    .nfull         (nfull),
    .nempty        (nempty)
`ifdef FIFO_ACCESS_MASTER_STATS_EN
    ,
    .wr_count      (wr_count),
    .rd_count      (rd_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: age = cycles since accept (0 = idle).
  // Strobe low for age 1..S, rsp on S+1, idle again after S+G.
  int           age;
  logic         m_rw;
  logic [W-1:0] m_in;
  logic [W-1:0] m_rdata;
  logic         m_rsp_rw;
  int           m_wr, m_rd, m_st;

  int falls[$];
  int rsp_cyc[$];
  int rsp_dat[$];
  int rsp_rwq[$];
  int wr_low, rd_low;
  logic prev_wr;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic int qat(int q[$], int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  function automatic logic m_rdy();
    return !rst && age == 0 && (cmd_rw ? nempty : nfull);
  endfunction

  function automatic int sat(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = 0; m_rw = 0; m_in = 0; m_rdata = 0; m_rsp_rw = 0;
      m_wr = 0; m_rd = 0; m_st = 0;
    end else if (age == 0) begin
      if (cmd_valid && !m_rdy()) m_st = sat(m_st);
      if (cmd_valid && m_rdy()) begin
        age  = 1;
        m_rw = cmd_rw;
        if (!cmd_rw) m_in = cmd_wdata;
      end
    end else begin
      if (age == S) begin
        m_rsp_rw = m_rw;
        if (m_rw) begin
          m_rdata = fifo_out_data;
          m_rd = sat(m_rd);
        end else begin
          m_wr = sat(m_wr);
        end
      end
      age = (age == S + G) ? 0 : age + 1;
    end
  end

  always @(negedge clk) begin
    logic low;
    low = (age >= 1 && age <= S);
    chk("fifowr", fifowr, !(low && !m_rw));
    chk("fiford", fiford, !(low && m_rw));
    chk("cmd_ready", cmd_ready, m_rdy());
    chk("rsp_valid", rsp_valid, age == S + 1);
    chk("fifo_in_data", fifo_in_data, m_in);
    if (age == S + 1) chk("rsp_rw", rsp_rw, m_rsp_rw);
    if (age == S + 1 && m_rw) chk("rsp_rdata", rsp_rdata, m_rdata);
`ifdef FIFO_ACCESS_MASTER_STATS_EN
    chk("wr_count", wr_count, m_wr);
    chk("rd_count", rd_count, m_rd);
    chk("stall_count", stall_count, m_st);
`endif
    if (prev_wr === 1'b1 && fifowr === 1'b0) falls.push_back(cyc);
    if (fifowr === 1'b0) wr_low++;
    if (fiford === 1'b0) rd_low++;
    if (rsp_valid === 1'b1) begin
      rsp_cyc.push_back(cyc);
      rsp_dat.push_back(int'(rsp_rdata));
      rsp_rwq.push_back(int'(rsp_rw));
    end
    prev_wr = fifowr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    falls.delete(); rsp_cyc.delete(); rsp_dat.delete(); rsp_rwq.delete();
    wr_low = 0; rd_low = 0;
  endtask

  task automatic do_cmd(input logic rw, input logic [W-1:0] d,
                        output int acc, input bit keep);
    bit got;
    got = 0;
    acc = -1;
    cmd_valid = 1; cmd_rw = rw; cmd_wdata = d;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        got = 1;
        acc = cyc;
      end
      tick();
    end
    if (!got) chk("accept_timeout", 0, 1);
    if (!keep) cmd_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a1, a2, s0, n0;
    rst = 1; cmd_valid = 0; cmd_rw = 0; cmd_wdata = 0;
    fifo_out_data = 0; nfull = 0; nempty = 0; prev_wr = 1;
    clr();
    repeat (3) @(posedge clk);
    #1 rst = 0;

    repeat (4) tick();
    chk("idle_fifowr", fifowr, 1);
    chk("idle_fiford", fiford, 1);
    chk("idle_ready", cmd_ready, 0);
    chk("idle_norsp", rsp_cyc.size(), 0);

    nfull = 1; clr();
    do_cmd(0, 8'hA5, a1, 0);
    repeat (8) tick();
    chk("wr_fall", qat(falls, 0), a1 + 1);
    chk("wr_low_len", wr_low, 3);
    chk("wr_rsp_cyc", qat(rsp_cyc, 0), a1 + 4);
    chk("wr_rsp_rw", qat(rsp_rwq, 0), 0);
    chk("wr_in_data", fifo_in_data, 8'hA5);

    nempty = 1; fifo_out_data = 8'h3C; clr();
    do_cmd(1, 8'h00, a1, 0);
    repeat (8) tick();
    chk("rd_low_len", rd_low, 3);
    chk("rd_rsp_cyc", qat(rsp_cyc, 0), a1 + 4);
    chk("rd_rsp_rw", qat(rsp_rwq, 0), 1);
    chk("rd_rsp_data", qat(rsp_dat, 0), 8'h3C);

    clr();
    do_cmd(0, 8'h01, a1, 1);
    do_cmd(0, 8'h02, a2, 0);
    repeat (10) tick();
    chk("b2b_first_fall", qat(falls, 0), a1 + 1);
    chk("b2b_spacing", qat(falls, 1) - qat(falls, 0), 6);
    chk("b2b_gap_ok", (qat(falls, 1) - qat(falls, 0) - S) >= 2, 1);
    chk("b2b_in_data", fifo_in_data, 8'h02);

    clr();
    nfull = 0; cmd_valid = 1; cmd_rw = 0; cmd_wdata = 8'h77;
    s0 = cyc;
`ifdef FIFO_ACCESS_MASTER_STATS_EN
    n0 = int'(stall_count);
`endif
    repeat (5) tick();
    chk("stall_no_strobe", wr_low, 0);
    nfull = 1;
    do_cmd(0, 8'h77, a1, 0);
    chk("stall_accept_cyc", a1, s0 + 5);
`ifdef FIFO_ACCESS_MASTER_STATS_EN
    chk("stall_count5", int'(stall_count) - n0, 5);
`endif
    repeat (8) tick();

    nempty = 1; fifo_out_data = 8'h5A; clr();
    do_cmd(1, 8'h00, a1, 0);
    tick();
    chk("pre_rst_fiford", fiford, 0);
    rst = 1;
    #1;
    chk("rst_fiford", fiford, 1);
    tick(); tick();
    rst = 0;
    repeat (8) tick();
    chk("rst_no_rsp", rsp_cyc.size(), 0);
    fifo_out_data = 8'hC3;
    do_cmd(1, 8'h00, a1, 0);
    repeat (8) tick();
    chk("post_rst_rsp_cyc", qat(rsp_cyc, 0), a1 + 4);
    chk("post_rst_rsp_data", qat(rsp_dat, 0), 8'hC3);

    repeat (3000) begin
      cmd_valid     = ($urandom_range(0, 2) != 0);
      cmd_rw        = $urandom_range(0, 1);
      cmd_wdata     = W'($urandom);
      nfull         = ($urandom_range(0, 3) != 0);
      nempty        = ($urandom_range(0, 3) != 0);
      fifo_out_data = W'($urandom);
      tick();
    end
    cmd_valid = 0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_access_master.md
Name: fifo_access_master

Overview:
- User-side initiator for the SRAM-backed FIFO controller.
- Converts a local command stream (valid/ready, one byte per command) into the controller's active-low fifowr/fiford strobe protocol.
- Guarantees minimum strobe-low and strobe-gap timing.
- Returns read bytes and write completions on a response port; sits between datapath logic and the FIFO controller.

Parameters:
- STROBE_CYCLES, 3, cycles a strobe is held low; legal range 3..15.
- GAP_CYCLES, 2, cycles both strobes stay high after a release before the next strobe; legal range 2..15.
- DATA_W, 8, FIFO data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when valid and ready are both high.
- cmd_rw  input  1  0 = write to FIFO, 1 = read from FIFO.
- cmd_wdata  input  DATA_W  byte to write; ignored for reads.
- rsp_valid  output  1  one-cycle pulse, access complete.
- rsp_rw  output  1  echo of cmd_rw for the completed access.
- rsp_rdata  output  DATA_W  read byte, valid with rsp_valid when rsp_rw = 1.
- fifowr  output  1  FIFO write strobe, active low.
- fiford  output  1  FIFO read strobe, active low.
- fifo_in_data  output  DATA_W  data to the FIFO controller's input bus.
- fifo_out_data  input  DATA_W  data from the FIFO controller's output bus.
- nfull  input  1  FIFO not full (high = room available).
- nempty  input  1  FIFO not empty (high = data available).

Behaviour:
- Reset (asynchronous, active-high): state IDLE; fifowr = 1; fiford = 1; cmd_ready = 0; rsp_valid = 0; rsp_rw = 0; rsp_rdata = 0; fifo_in_data = 0; counter = 0.
- cmd_ready is combinational. It is 1 only in IDLE, and only when (cmd_rw = 0 and nfull = 1) or (cmd_rw = 1 and nempty = 1). A write to a full FIFO or a read from an empty FIFO stalls; nothing is dropped.
- IDLE, on accept:
  - latch cmd_rw; for writes, latch cmd_wdata into fifo_in_data;
  - drive the selected strobe low from the next cycle; go to ASSERT; load counter with STROBE_CYCLES-1.
- ASSERT:
  - selected strobe held low; fifo_in_data held stable; counter decrements.
  - When counter = 0:
    - for reads, capture fifo_out_data into rsp_rdata;
    - go to RELEASE with the strobe high from the next cycle;
    - load counter with GAP_CYCLES-1.
- RELEASE:
  - both strobes high; fifo_in_data held until RELEASE ends.
  - rsp_valid pulses on the first RELEASE cycle.
  - When counter = 0, go to IDLE.
- Strobes are never low simultaneously. Strobe edges are glitch-free register outputs.
- Throughput: one access per STROBE_CYCLES + GAP_CYCLES + 1 cycles. With defaults, 6 cycles.
- Latency: accept -> strobe low is 1 cycle; accept -> rsp_valid is STROBE_CYCLES+1 cycles.
- nfull/nempty are sampled only at accept. A status change during ASSERT/RELEASE does not abort the access.
- cmd_valid may drop while stalled; there is no requirement to hold it.
- Reset mid-access: strobes return high immediately (asynchronous); no rsp_valid is issued for the aborted access.

Optional Feature:
- Macro FIFO_ACCESS_MASTER_STATS_EN.
- When defined, add outputs wr_count[15:0] and rd_count[15:0]:
  - each increments on rsp_valid of its type and saturates at 16'hFFFF;
  - reset to 0.
- Also add output stall_count[15:0]: counts cycles with cmd_valid = 1, state IDLE, and cmd_ready = 0; saturating; reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package fifo_if_pkg holds:
  - state encoding constants ST_IDLE, ST_ASSERT, ST_RELEASE;
  - default STROBE_CYCLES/GAP_CYCLES;
  - FIFO data width 8 and address width 11, shared with the FIFO controller.
- One natural sub-module: fifo_strobe_timer, a loadable down-counter with a zero flag, used by both ASSERT and RELEASE.

Test Plan:
- Reset held, then released with no command -> fifowr = fiford = 1, cmd_ready = 0 while cmd_valid = 0, rsp_valid never pulses.
- Write 8'hA5 with nfull = 1 -> fifowr low for exactly 3 cycles starting 1 cycle after accept; fifo_in_data = 8'hA5 throughout; rsp_valid with rsp_rw = 0 at accept+4.
- Read with nempty = 1, fifo_out_data = 8'h3C during ASSERT -> fiford low 3 cycles; rsp_valid at accept+4 with rsp_rdata = 8'h3C.
- Back-to-back writes 8'h01, 8'h02 held valid -> second fifowr falling edge exactly 6 cycles after the first; at least 2 high cycles between strobes.
- Write with nfull = 0 for 5 cycles, then nfull = 1 -> cmd_ready = 0 and fifowr = 1 for those 5 cycles; accept on the cycle nfull rises; with STATS_EN, stall_count = 5.
- Assert rst on the 2nd ASSERT cycle of a read -> fiford high in the same cycle; no rsp_valid; next command proceeds normally after rst deasserts.
